// File: rtl/sr_counter_pkg.sv
// Shared types and constants for the multi-channel start/stop counter.
package sr_counter_pkg;

   // Per-channel control state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } chan_state_e;

   // Terminal behaviour selectors for the MODE parameter
   localparam int MODE_WRAP    = 0;
   localparam int MODE_SAT     = 1;
   localparam int MODE_ONESHOT = 2;

endpackage

// File: rtl/sr_counter_chan.sv
// One counter channel: IDLE/RUN/HOLD/DONE control with a registered count,
// terminal pulse and sticky wrap flag.
module sr_counter_chan
   import sr_counter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   chan_state_e      state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   // Remembers that saturation was already reported, so tc fires once
   logic             sat_q, sat_d;
   logic             terminal;

   // Command priority: clear > load > stop > start > count step
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      tc_d     = 1'b0;
      ovf_d    = ovf_q;
      sat_d    = sat_q;
      terminal = up ? (count_q >= limit) : (count_q == '0);

      if (clear) begin
         state_d = IDLE;
         count_d = '0;
         ovf_d   = 1'b0;
         sat_d   = 1'b0;
      end else if (load) begin
         count_d = load_val;
         sat_d   = 1'b0;
      end else if (stop) begin
         // stop also blocks a simultaneous start in every state
         if (state_q == RUN) begin
            state_d = HOLD;
         end
      end else if (start && (state_q != RUN)) begin
         // Entering RUN takes one edge; the first step happens on the next
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (!terminal) begin
            count_d = up ? (count_q + ONE) : (count_q - ONE);
            sat_d   = 1'b0;
         end else begin
            case (MODE)
               MODE_SAT: begin
                  tc_d  = ~sat_q;
                  sat_d = 1'b1;
               end
               MODE_ONESHOT: begin
                  tc_d    = 1'b1;
                  state_d = DONE;
               end
               default: begin
                  count_d = up ? '0 : limit;
                  tc_d    = 1'b1;
                  ovf_d   = 1'b1;
               end
            endcase
         end
      end
   end

   // Channel state registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         sat_q   <= sat_d;
      end
   end

   assign count   = count_q;
   assign running = (state_q == RUN);
   assign tc      = tc_q;
   assign ovf     = ovf_q;

endmodule

// File: rtl/sr_counter_multi.sv
// Bank of CHANNELS independent counters sharing one clock, reset and limit.
module sr_counter_multi
   import sr_counter_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MODE     = MODE_WRAP
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       clear,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   input  logic [CHANNELS-1:0]       up,
   input  logic [WIDTH-1:0]          limit,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       running,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS-1:0]       ovf
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      sr_counter_chan #(
         .WIDTH (WIDTH),
         .MODE  (MODE)
      ) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .start    (start[i]),
         .stop     (stop[i]),
         .clear    (clear[i]),
         .load     (load[i]),
         .load_val (load_val[i*WIDTH +: WIDTH]),
         .up       (up[i]),
         .limit    (limit),
         .count    (count[i*WIDTH +: WIDTH]),
         .running  (running[i]),
         .tc       (tc[i]),
         .ovf      (ovf[i])
      );
   end

endmodule

// File: tb/tb_sr_counter_multi.sv
// Directed bench for sr_counter_multi: one instance per terminal mode.
module tb_sr_counter_multi;

   logic        clk;
   logic        reset_n;
   logic [3:0]  start, stop, clear, load, up;
   logic [15:0] load_val;
   logic [3:0]  limit;

   logic [15:0] cnt_w, cnt_s, cnt_o;
   logic [3:0]  run_w, run_s, run_o;
   logic [3:0]  tc_w, tc_s, tc_o;
   logic [3:0]  ovf_w, ovf_s, ovf_o;

   int checks = 0;
   int errors = 0;

   sr_counter_multi #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_wrap (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
      .load(load), .load_val(load_val), .up(up), .limit(limit),
      .count(cnt_w), .running(run_w), .tc(tc_w), .ovf(ovf_w));

   sr_counter_multi #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_sat (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
      .load(load), .load_val(load_val), .up(up), .limit(limit),
      .count(cnt_s), .running(run_s), .tc(tc_s), .ovf(ovf_s));

   sr_counter_multi #(.WIDTH(4), .CHANNELS(4), .MODE(2)) u_one (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
      .load(load), .load_val(load_val), .up(up), .limit(limit),
      .count(cnt_o), .running(run_o), .tc(tc_o), .ovf(ovf_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = '0; stop = '0; clear = '0; load = '0; up = '0;
      load_val = '0; limit = 4'd9;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      start = 4'hF; stop = '0; clear = '0; load = '0; up = 4'hF;
      load_val = '0; limit = 4'd9;
      reset_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({cnt_w, cnt_s, cnt_o} !== 48'h0) begin
         errors++; $display("FAIL reset_count got %h exp 0", {cnt_w, cnt_s, cnt_o});
      end
      checks++;
      if ({run_w, run_s, run_o} !== 12'h0) begin
         errors++; $display("FAIL reset_running got %h exp 0", {run_w, run_s, run_o});
      end
      checks++;
      if ({tc_w, tc_s, tc_o, ovf_w, ovf_s, ovf_o} !== 24'h0) begin
         errors++; $display("FAIL reset_tc_ovf got %h exp 0", {tc_w, tc_s, tc_o, ovf_w, ovf_s, ovf_o});
      end
      reset_n = 1'b1;
      start = '0;
   endtask

   task automatic test_wrap();
      logic [3:0] exp_c;
      logic       exp_t, exp_v;
      do_reset();
      up = 4'hF; limit = 4'd9; start = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_c = (i <= 9) ? 4'(i) : 4'(i - 10);
         exp_t = (i == 10);
         exp_v = (i >= 10);
         checks++;
         if (cnt_w[3:0] !== exp_c) begin
            errors++; $display("FAIL wrap_count i=%0d got %0d exp %0d", i, cnt_w[3:0], exp_c);
         end
         checks++;
         if (tc_w[0] !== exp_t) begin
            errors++; $display("FAIL wrap_tc i=%0d got %b exp %b", i, tc_w[0], exp_t);
         end
         checks++;
         if (ovf_w[0] !== exp_v) begin
            errors++; $display("FAIL wrap_ovf i=%0d got %b exp %b", i, ovf_w[0], exp_v);
         end
      end
      checks++;
      if (cnt_w[15:4] !== 12'h0) begin
         errors++; $display("FAIL wrap_idle_chans got %h exp 0", cnt_w[15:4]);
      end
      start = '0;
   endtask

   task automatic test_limit_zero();
      do_reset();
      up = 4'hF; limit = 4'd0; start = 4'b0001;
      step();
      checks++;
      if ({run_w[0], tc_w[0], cnt_w[3:0]} !== 6'b10_0000) begin
         errors++; $display("FAIL lim0_enter got %b exp 100000", {run_w[0], tc_w[0], cnt_w[3:0]});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({run_w[0], tc_w[0], ovf_w[0], cnt_w[3:0]} !== 7'b111_0000) begin
            errors++; $display("FAIL lim0_step i=%0d got %b exp 1110000", i,
                               {run_w[0], tc_w[0], ovf_w[0], cnt_w[3:0]});
         end
      end
      start = '0;
   endtask

   task automatic test_sat();
      logic [3:0] exp_c [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
      logic       exp_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      up = 4'h0; limit = 4'd9; load_val = 16'h0003; load = 4'b0001;
      step();
      checks++;
      if ({run_s[0], cnt_s[3:0]} !== 5'b0_0011) begin
         errors++; $display("FAIL sat_load got %b exp 00011", {run_s[0], cnt_s[3:0]});
      end
      load = '0; start = 4'b0001;
      step();
      checks++;
      if ({run_s[0], cnt_s[3:0]} !== 5'b1_0011) begin
         errors++; $display("FAIL sat_start got %b exp 10011", {run_s[0], cnt_s[3:0]});
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (cnt_s[3:0] !== exp_c[i]) begin
            errors++; $display("FAIL sat_count i=%0d got %0d exp %0d", i, cnt_s[3:0], exp_c[i]);
         end
         checks++;
         if (tc_s[0] !== exp_t[i]) begin
            errors++; $display("FAIL sat_tc i=%0d got %b exp %b", i, tc_s[0], exp_t[i]);
         end
         checks++;
         if ({run_s[0], ovf_s[0]} !== 2'b10) begin
            errors++; $display("FAIL sat_run_ovf i=%0d got %b exp 10", i, {run_s[0], ovf_s[0]});
         end
      end
      start = '0;
   endtask

   task automatic test_oneshot();
      do_reset();
      up = 4'hF; limit = 4'd9; start = 4'b0001;
      step();
      start = '0;
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++;
         if ({run_o[0], tc_o[0], cnt_o[3:0]} !== {2'b10, 4'(k)}) begin
            errors++; $display("FAIL one_count k=%0d got %b exp %b", k,
                               {run_o[0], tc_o[0], cnt_o[3:0]}, {2'b10, 4'(k)});
         end
      end
      step();
      checks++;
      if ({run_o[0], tc_o[0], cnt_o[3:0]} !== 6'b01_1001) begin
         errors++; $display("FAIL one_done got %b exp 011001", {run_o[0], tc_o[0], cnt_o[3:0]});
      end
      step();
      checks++;
      if ({run_o[0], tc_o[0], cnt_o[3:0]} !== 6'b00_1001) begin
         errors++; $display("FAIL one_stay got %b exp 001001", {run_o[0], tc_o[0], cnt_o[3:0]});
      end
      start = 4'b0001;
      step();
      checks++;
      if ({run_o[0], tc_o[0], cnt_o[3:0]} !== 6'b10_1001) begin
         errors++; $display("FAIL one_restart got %b exp 101001", {run_o[0], tc_o[0], cnt_o[3:0]});
      end
      start = '0;
      step();
      checks++;
      if ({run_o[0], tc_o[0], cnt_o[3:0]} !== 6'b01_1001) begin
         errors++; $display("FAIL one_retc got %b exp 011001", {run_o[0], tc_o[0], cnt_o[3:0]});
      end
   endtask

   task automatic test_start_stop();
      do_reset();
      up = 4'hF; limit = 4'd9; start = 4'b0001;
      step();
      repeat (5) step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b1_0101) begin
         errors++; $display("FAIL ss_run5 got %b exp 10101", {run_w[0], cnt_w[3:0]});
      end
      stop = 4'b0001;
      step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b0_0101) begin
         errors++; $display("FAIL ss_hold got %b exp 00101", {run_w[0], cnt_w[3:0]});
      end
      step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b0_0101) begin
         errors++; $display("FAIL ss_hold2 got %b exp 00101", {run_w[0], cnt_w[3:0]});
      end
      start = '0; stop = '0; clear = 4'b0001; load = 4'b0001; load_val = 16'h0007;
      step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b0_0000) begin
         errors++; $display("FAIL ss_clear_load got %b exp 00000", {run_w[0], cnt_w[3:0]});
      end
      clear = '0; load = '0; start = 4'b0001; stop = 4'b0001;
      step();
      checks++;
      if (run_w[0] !== 1'b0) begin
         errors++; $display("FAIL ss_idle_both got %b exp 0", run_w[0]);
      end
      stop = '0;
      step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b1_0000) begin
         errors++; $display("FAIL ss_restart got %b exp 10000", {run_w[0], cnt_w[3:0]});
      end
      start = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      up = 4'hF; limit = 4'd9; start = 4'b0001;
      step();
      repeat (6) step();
      checks++;
      if (cnt_w[3:0] !== 4'd6) begin
         errors++; $display("FAIL mid_pre got %0d exp 6", cnt_w[3:0]);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b0_0000) begin
         errors++; $display("FAIL mid_async got %b exp 00000", {run_w[0], cnt_w[3:0]});
      end
      start = '0;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({run_w[0], cnt_w[3:0]} !== 5'b0_0000) begin
            errors++; $display("FAIL mid_quiet i=%0d got %b exp 00000", i, {run_w[0], cnt_w[3:0]});
         end
      end
      start = 4'b0001;
      step();
      step();
      checks++;
      if ({run_w[0], cnt_w[3:0]} !== 5'b1_0001) begin
         errors++; $display("FAIL mid_resume got %b exp 10001", {run_w[0], cnt_w[3:0]});
      end
      start = '0;
   endtask

   task automatic test_multi();
      logic [15:0] exp_v;
      do_reset();
      up = 4'b0001; limit = 4'd9;
      load_val = 16'h0350; load = 4'b0110;
      step();
      checks++;
      if (cnt_w !== 16'h0350) begin
         errors++; $display("FAIL multi_load got %h exp 0350", cnt_w);
      end
      load = '0; start = 4'b1111; clear = 4'b1000;
      step();
      checks++;
      if (run_w !== 4'b0111) begin
         errors++; $display("FAIL multi_start got %b exp 0111", run_w);
      end
      start = 4'b0011; stop = 4'b0100;
      for (int k = 1; k <= 3; k++) begin
         step();
         exp_v = {4'd0, 4'd3, 4'(5 - k), 4'(k)};
         checks++;
         if (cnt_w !== exp_v) begin
            errors++; $display("FAIL multi_count k=%0d got %h exp %h", k, cnt_w, exp_v);
         end
         checks++;
         if (run_w !== 4'b0011) begin
            errors++; $display("FAIL multi_run k=%0d got %b exp 0011", k, run_w);
         end
      end
      start = '0; stop = '0; clear = '0;
   endtask

   initial begin
      reset_n = 1'b0;
      start = '0; stop = '0; clear = '0; load = '0; up = '0;
      load_val = '0; limit = '0;
      #3;
      test_reset();
      test_wrap();
      test_limit_zero();
      test_sat();
      test_oneshot();
      test_start_stop();
      test_reset_mid();
      test_multi();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_counter_multi.md
SR_COUNTER_MULTI -- requirements
Module: sr_counter_multi

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the count width per channel in bits (legal range 2..32).
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent counter channels (legal range 1..16).
REQ-003 Parameter MODE, default 0, SHALL select the terminal behaviour: 0 = wrap, 1 = saturate, 2 = one-shot.
REQ-004 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 Port start  input  CHANNELS  SHALL be the per-channel run request, level-sampled each cycle.
REQ-007 Port stop  input  CHANNELS  SHALL be the per-channel pause request.
REQ-008 Port clear  input  CHANNELS  SHALL be the per-channel synchronous clear to IDLE with count 0.
REQ-009 Port load  input  CHANNELS  SHALL be the per-channel synchronous load strobe.
REQ-010 Port load_val  input  CHANNELS*WIDTH  SHALL be the load values, with channel i at bits [i*WIDTH +: WIDTH].
REQ-011 Port up  input  CHANNELS  SHALL be the count direction per channel: 1 = increment, 0 = decrement.
REQ-012 Port limit  input  WIDTH  SHALL be the terminal value shared by all channels.
REQ-013 Port count  output  CHANNELS*WIDTH  SHALL carry the registered count values, packed as load_val.
REQ-014 Port running  output  CHANNELS  SHALL be 1 exactly while a channel is in RUN.
REQ-015 Port tc  output  CHANNELS  SHALL pulse high for one cycle when a channel reaches terminal.
REQ-016 Port ovf  output  CHANNELS  SHALL be a sticky flag, set on any wrap and cleared only by clear or reset.

Function
REQ-017 Each channel SHALL implement a state machine with the states IDLE, RUN, HOLD and DONE.
REQ-018 Per-channel command priority SHALL be clear > load > stop > start > count step.
REQ-019 clear SHALL force state IDLE, count 0, ovf 0 and tc 0 on the next edge, from any state.
REQ-020 load SHALL set count = load_val on the next edge, leave the state unchanged and suppress that cycle's count step.
REQ-021 start in IDLE, HOLD or DONE SHALL enter RUN on the next edge, and the first count step SHALL occur one edge later.
REQ-022 stop in RUN SHALL enter HOLD with count frozen; stop in any other state SHALL have no effect.
REQ-023 Simultaneous start and stop SHALL result in stop winning: RUN goes to HOLD, and IDLE or HOLD are unchanged.
REQ-024 In RUN with up=1, terminal SHALL be count >= limit; with up=0, terminal SHALL be count == 0.
REQ-025 A non-terminal step SHALL perform count +/- 1 modulo 2^WIDTH.
REQ-026 In MODE 0, terminal SHALL reload count to 0 (up) or to limit (down), pulse tc and set ovf.
REQ-027 In MODE 1, terminal SHALL hold count, pulse tc only on the first terminal cycle, stay in RUN and leave ovf unchanged.
REQ-028 In MODE 2, terminal SHALL hold count, pulse tc and move to DONE; start from DONE SHALL restart from the current count.
REQ-029 When limit = 0 and up = 1, every RUN cycle SHALL be terminal.
REQ-030 Channels SHALL be fully independent, with no cross-channel interaction except the shared limit.
REQ-031 Output latency SHALL be one cycle: count, running and tc are all registered.

Reset
REQ-032 While reset_n = 0, every channel SHALL be in IDLE with count = 0, running = 0, tc = 0 and ovf = 0, regardless of clk.
REQ-033 Reset asserted mid-operation SHALL abort RUN immediately; after release, no count step SHALL occur until a new start.

Structure
REQ-034 Package sr_counter_pkg SHALL hold the state enum (IDLE, RUN, HOLD, DONE) and the MODE constants MODE_WRAP, MODE_SAT and MODE_ONESHOT.
REQ-035 Sub-module sr_counter_chan SHALL implement one channel and SHALL be instantiated CHANNELS times by a generate loop.

Verification
REQ-036 Directed scenarios (WIDTH=4, limit=9):
- MODE 0: start ch0 for 12 cycles -> count 0..9, 0, 1; tc high one cycle at the 9 to 0 step; ovf = 1.
- MODE 1: up=0 with load_val=3, load then start -> count 2, 1, 0, 0 ...; tc pulses once; running stays 1.
- MODE 2: start -> count reaches 9, tc pulses, running = 0, state DONE; a further start -> tc pulses again next step.
- start and stop asserted together in RUN with count=5 -> HOLD, count stays 5; clear and load together -> count 0, IDLE.
- reset_n asserted mid-RUN at count=6 -> count 0 and running 0 asynchronously; no step after release until start.
- CHANNELS=4: ch0 up, ch1 down, ch2 held, ch3 cleared each cycle -> all values independent and correct per channel.
